sal_dfi_cmd_arb: RTL and testbench

- Shares the single DFI command slot among N_BANK per-bank controllers inside the SAL DDR2 controller.
- Each cycle it picks at most one eligible request (ACT/RD/WR/PRE) by round-robin, subject to inter-command timing: tRRD, tCCD, tWTR, tRTW.
- Returns a one-hot grant to the winning bank and drives a registered command/bank toward the DFI control encoder.
- Bank-local timing (tRCD, tRP, tRAS) stays in the bank controllers.

---
 rtl/sal_dfi_cmd_arb.sv | 147 ++++++++++++++
 tb/tb_sal_dfi_cmd_arb.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sal_dfi_cmd_arb.sv
// sal_dfi_cmd_arb: round-robin arbiter sharing the single DFI command slot
// among N_BANK bank controllers, enforcing tRRD/tCCD/tWTR/tRTW between grants.
// Optional build macro: SAL_CAS_PRIORITY_EN -- RD/WR requests win over ACT/PRE
// (two-pass selection); undefined gives plain single-pass round-robin.
module sal_dfi_cmd_arb #(
  parameter int N_BANK = 4,
  parameter int BA_W   = 2,
  parameter int T_RRD  = 2,
  parameter int T_CCD  = 2,
  parameter int T_WTR  = 6,
  parameter int T_RTW  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_BANK-1:0]   req_valid_i,
  input  logic [2*N_BANK-1:0] req_cmd_i,
  input  logic                block_i,
  output logic [N_BANK-1:0]   grant_o,
  output logic                cmd_valid_o,
  output logic [1:0]          cmd_o,
  output logic [BA_W-1:0]     cmd_ba_o,
  output logic                idle_o
);

  localparam logic [1:0] CMD_ACT = 2'b00;
  localparam logic [1:0] CMD_RD  = 2'b01;
  localparam logic [1:0] CMD_WR  = 2'b10;

  // Reload values: T of 0 and 1 both mean "no added gap".
  localparam logic [3:0] RRD_LD = 4'((T_RRD > 1) ? T_RRD - 1 : 0);
  localparam logic [3:0] CCD_LD = 4'((T_CCD > 1) ? T_CCD - 1 : 0);
  localparam logic [3:0] WTR_LD = 4'((T_WTR > 1) ? T_WTR - 1 : 0);
  localparam logic [3:0] RTW_LD = 4'((T_RTW > 1) ? T_RTW - 1 : 0);

  logic [BA_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [3:0]        rrd_q, rrd_d, ccd_q, ccd_d, wtr_q, wtr_d, rtw_q, rtw_d;
  logic              cmd_valid_q;
  logic [1:0]        cmd_q, cmd_d;
  logic [BA_W-1:0]   cmd_ba_q, cmd_ba_d;

  logic [N_BANK-1:0] elig, cas, sel_mask;
  logic              found;
  logic [BA_W-1:0]   gnt_idx;
  logic [1:0]        gnt_cmd;

  // Per-bank eligibility against the shared inter-command timers.
  for (genvar b = 0; b < N_BANK; b++) begin : g_elig
    logic [1:0] c;
    assign c = req_cmd_i[2*b +: 2];
    assign cas[b] = (c == CMD_RD) || (c == CMD_WR);
    always_comb begin
      unique case (c)
        CMD_ACT: elig[b] = (rrd_q == 4'd0);
        CMD_RD:  elig[b] = (ccd_q == 4'd0) && (wtr_q == 4'd0);
        CMD_WR:  elig[b] = (ccd_q == 4'd0) && (rtw_q == 4'd0);
        default: elig[b] = 1'b1;
      endcase
      elig[b] = elig[b] & req_valid_i[b] & ~block_i;
    end
  end

  // Candidate set: with CAS priority, ACT/PRE only compete when no RD/WR can go.
  always_comb begin
`ifdef SAL_CAS_PRIORITY_EN
    if (|(elig & cas)) sel_mask = elig & cas;
    else               sel_mask = elig & ~cas;
`else
    sel_mask = elig;
`endif
  end

  // Round-robin scan starting at rr_ptr; first candidate wins.
  always_comb begin
    int idx;
    found   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int i = 0; i < N_BANK; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= N_BANK) idx = idx - N_BANK;
      if (!found && sel_mask[idx]) begin
        found   = 1'b1;
        gnt_idx = BA_W'(idx);
      end
    end
  end

  assign gnt_cmd = req_cmd_i[{gnt_idx, 1'b0} +: 2];

  // One-hot grant, forced low while reset is asserted.
  always_comb begin
    grant_o = '0;
    if (found && rst_n) grant_o[gnt_idx] = 1'b1;
  end

  // Next state: pointer follows winner, timers decrement or reload on grant.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    cmd_d    = cmd_q;
    cmd_ba_d = cmd_ba_q;
    rrd_d    = (rrd_q != 4'd0) ? rrd_q - 4'd1 : 4'd0;
    ccd_d    = (ccd_q != 4'd0) ? ccd_q - 4'd1 : 4'd0;
    wtr_d    = (wtr_q != 4'd0) ? wtr_q - 4'd1 : 4'd0;
    rtw_d    = (rtw_q != 4'd0) ? rtw_q - 4'd1 : 4'd0;
    if (found) begin
      rr_ptr_d = (gnt_idx == BA_W'(N_BANK - 1)) ? '0 : gnt_idx + BA_W'(1);
      cmd_d    = gnt_cmd;
      cmd_ba_d = gnt_idx;
      unique case (gnt_cmd)
        CMD_ACT: rrd_d = RRD_LD;
        CMD_RD:  begin ccd_d = CCD_LD; rtw_d = RTW_LD; end
        CMD_WR:  begin ccd_d = CCD_LD; wtr_d = WTR_LD; end
        default: ;
      endcase
    end
  end

  // State registers; async reset drops any registered command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      rrd_q       <= '0;
      ccd_q       <= '0;
      wtr_q       <= '0;
      rtw_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= 2'b00;
      cmd_ba_q    <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rrd_q       <= rrd_d;
      ccd_q       <= ccd_d;
      wtr_q       <= wtr_d;
      rtw_q       <= rtw_d;
      cmd_valid_q <= found;
      cmd_q       <= cmd_d;
      cmd_ba_q    <= cmd_ba_d;
    end
  end

  assign cmd_valid_o = cmd_valid_q;
  assign cmd_o       = cmd_q;
  assign cmd_ba_o    = cmd_ba_q;
  assign idle_o      = (rrd_q == 4'd0) && (ccd_q == 4'd0) && (wtr_q == 4'd0) &&
                       (rtw_q == 4'd0) && !(|req_valid_i);

endmodule

// File: tb/tb_sal_dfi_cmd_arb.sv
// Directed bench for sal_dfi_cmd_arb: fairness, timing gaps, block, priority,
// async reset. A second instance with T_RTW=1 covers the tCCD-limited case.
module tb_sal_dfi_cmd_arb;

  logic       gclk = 1'b0;
  logic       rst_n;
  logic [3:0] req_valid;
  logic [7:0] req_cmd;
  logic       block;
  logic [3:0] grant, grant1;
  logic       cmd_valid, cmd_valid1;
  logic [1:0] cmd, cmd1;
  logic [1:0] ba, ba1;
  logic       idle, idle1;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 gclk = ~gclk;

  sal_dfi_cmd_arb u_dut (
    .clk(gclk), .rst_n(rst_n), .req_valid_i(req_valid), .req_cmd_i(req_cmd),
    .block_i(block), .grant_o(grant), .cmd_valid_o(cmd_valid), .cmd_o(cmd),
    .cmd_ba_o(ba), .idle_o(idle)
  );

  sal_dfi_cmd_arb #(.T_RTW(1)) u_dut1 (
    .clk(gclk), .rst_n(rst_n), .req_valid_i(req_valid), .req_cmd_i(req_cmd),
    .block_i(block), .grant_o(grant1), .cmd_valid_o(cmd_valid1), .cmd_o(cmd1),
    .cmd_ba_o(ba1), .idle_o(idle1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge (start of a new cycle).
  task automatic nxt();
    @(posedge gclk);
    #1;
  endtask

  // Reset both instances; returns at the start of cycle 0 with rst_n high.
  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; req_cmd = '0; block = 1'b0;
    repeat (2) @(posedge gclk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] exp_g;

    // Reset state, including grant suppression while rst_n is low.
    rst_n = 1'b0; block = 1'b0;
    req_valid = 4'hF; req_cmd = 8'hFF;
    #3;
    chk("rst_grant", grant, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd", cmd, 0);
    chk("rst_ba", ba, 0);
    chk("rst_idle_req", idle, 0);
    req_valid = '0;
    #1;
    chk("rst_idle_noreq", idle, 1);

    // Fairness: all banks hold PRE.
    do_reset();
    req_valid = 4'hF; req_cmd = 8'hFF;
    for (int c = 0; c < 6; c++) begin
      #4;
      chk($sformatf("fair_grant_c%0d", c), grant, 4'b1 << (c % 4));
      chk($sformatf("fair_cv_c%0d", c), cmd_valid, (c > 0));
      if (c > 0) begin
        chk($sformatf("fair_ba_c%0d", c), ba, (c - 1) % 4);
        chk($sformatf("fair_cmd_c%0d", c), cmd, 2'b11);
      end
      nxt();
    end

    // tRRD: ACT on banks 0 and 1.
    do_reset();
    req_valid = 4'b0011; req_cmd = 8'h00;
    #4; chk("rrd_c0", grant, 4'b0001);
    nxt(); req_valid = 4'b0010;
    #4; chk("rrd_c1", grant, 0);
    chk("rrd_c1_cv", cmd_valid, 1);
    chk("rrd_c1_cmd", cmd, 2'b00);
    chk("rrd_c1_ba", ba, 0);
    nxt();
    #4; chk("rrd_c2", grant, 4'b0010);
    chk("rrd_c2_cv", cmd_valid, 0);
    nxt(); req_valid = '0;

    // tWTR: bank0 WR at cycle 0, bank1 RD waits until cycle 6.
    do_reset();
    req_valid = 4'b0001; req_cmd = 8'b0000_0010;
    #4; chk("wtr_c0", grant, 4'b0001);
    nxt(); req_valid = 4'b0010; req_cmd = 8'b0000_0100;
    for (int c = 1; c <= 6; c++) begin
      #4;
      chk($sformatf("wtr_c%0d", c), grant, (c == 6) ? 4'b0010 : 4'b0000);
      nxt();
    end
    req_valid = '0;
    #4;
    chk("wtr_c7_cmd", cmd, 2'b01);
    chk("wtr_c7_ba", ba, 1);
    chk("wtr_c7_idle_busy", idle, 0);
    repeat (8) nxt();
    #4; chk("idle_after_drain", idle, 1);
    nxt();

    // tRTW: bank2 RD and bank3 WR; default T_RTW=4, second instance T_RTW=1.
    do_reset();
    req_valid = 4'b1100; req_cmd = 8'b1001_0000;
    for (int c = 0; c <= 4; c++) begin
      #4;
      exp_g = (c == 0) ? 4'b0100 : (c == 4) ? 4'b1000 : 4'b0000;
      chk($sformatf("rtw4_c%0d", c), grant, exp_g);
      if (c <= 2) begin
        exp_g = (c == 0) ? 4'b0100 : (c == 2) ? 4'b1000 : 4'b0000;
        chk($sformatf("rtw1_c%0d", c), grant1, exp_g);
      end
      nxt();
      if (c == 0) req_valid = 4'b1000;
    end
    req_valid = '0;

    // block_i: RD on banks 0,1 held off for cycles 0-4.
    do_reset();
    req_valid = 4'b0011; req_cmd = 8'b0000_0101; block = 1'b1;
    for (int c = 0; c <= 7; c++) begin
      if (c == 5) block = 1'b0;
      if (c == 6) req_valid = 4'b0010;
      #4;
      exp_g = (c == 5) ? 4'b0001 : (c == 7) ? 4'b0010 : 4'b0000;
      chk($sformatf("blk_c%0d", c), grant, exp_g);
      nxt();
    end
    req_valid = '0;

    // Priority: bank0 ACT vs bank1 RD with rr_ptr=0.
    do_reset();
    req_valid = 4'b0011; req_cmd = 8'b0000_0100;
    #4;
`ifdef SAL_CAS_PRIORITY_EN
    chk("cas_prio", grant, 4'b0010);
`else
    chk("cas_prio", grant, 4'b0001);
`endif
    nxt(); req_valid = '0;

    // Async reset mid-burst.
    do_reset();
    req_valid = 4'hF; req_cmd = 8'hFF;
    repeat (3) nxt();
    #2;
    chk("ar_pre_grant", grant, 4'b1000);
    chk("ar_pre_cv", cmd_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("ar_grant", grant, 0);
    chk("ar_cv", cmd_valid, 0);
    nxt();
    rst_n = 1'b1;
    #3;
    chk("ar_first_grant", grant, 4'b0001);
    chk("ar_first_cv", cmd_valid, 0);
    nxt();
    #3;
    chk("ar_first_ba", ba, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
